multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control FSM that turns the single-cycle RISC-V datapath into a multicycle one sharing one ALU and one unified instruction/data memory. Each instruction is sequenced through fetch, decode, execute, memory and writeback states, with per-state mux selects and write strobes. Sits beside the register file, ALU and memory port. Takes the opcode and ALU zero flag, plus a memory-ready handshake for stalls.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- op  input  7  opcode from instruction register, bits [6:0]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- mem_req  output  1  memory access in progress (FETCH, MEMREAD, MEMWRITE)
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address: 0=PC, 1=ALUOut
- MemWrite  output  1  data memory write
- IRWrite  output  1  instruction register (and OldPC) enable
- ResultSrc  output  2  00=ALUOut, 01=read data, 10=ALU result
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1 data
- ALUSrcB  output  2  00=rs2 data, 01=immediate, 10=constant 4
- ALUOp  output  2  00=add, 01=subtract (branch), 10=funct-decoded
- ImmSrc  output  2  00=I, 01=S, 10=B, 11=J
- RegWrite  output  1  register file write
- illegal  output  1  one-cycle pulse: unsupported opcode seen in DECODE
- state  output  4  current state code, for debug

## Operation
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10. Codes 11–15 are unreachable and return to FETCH on the next edge.
- Transitions:
  - FETCH → DECODE on mem_ready; otherwise hold.
  - DECODE by op:
    - 0000011 (lw) or 0100011 (sw) → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1101111 → JAL.
    - 1100011 → BEQ.
    - Anything else → FETCH, with illegal=1 in that DECODE cycle.
  - MEMADR → MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD → MEMWB on mem_ready; otherwise hold.
  - MEMWRITE → FETCH on mem_ready; otherwise hold.
  - MEMWB → FETCH.
  - EXECUTER and EXECUTEI → ALUWB.
  - ALUWB → FETCH.
  - JAL → ALUWB.
  - BEQ → FETCH.
- Moore outputs per state (unlisted signals are 0):
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, mem_req=1. IRWrite=mem_ready and PCWrite=mem_ready.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, mem_req=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1, mem_req=1. MemWrite is held for the whole stall.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero.
- ImmSrc is combinational from op in every state:
  - 0000011 and 0010011 → 00
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - anything else → 00

## Timing
- State register updates on the rising clk edge. All outputs are combinational from state, op, zero and mem_ready; there are no output registers.
- Reset: on a clk edge with rst_n=0, state=FETCH, regardless of the current state (reset mid-instruction aborts it).
- While rst_n=0, PCWrite, IRWrite, MemWrite, RegWrite, mem_req and illegal are forced to 0 combinationally. The first fetch starts in the cycle rst_n returns to 1.
- Cycles per instruction with mem_ready held at 1:
  - lw 5
  - sw 4
  - R-type 4
  - I-type ALU 4
  - jal 4
  - beq 3
  - unsupported opcode 2
- Each cycle with mem_ready=0 in a memory state adds 1 cycle. Stalls never repeat writes: IRWrite/PCWrite in FETCH pulse once, in the ready cycle only.
- The BEQ PCWrite is evaluated from zero in the BEQ cycle only.

## Configuration
- MULTICYCLE_JAL_EN:
  - Defined: the JAL state and the op=1101111 decode exist as described.
  - Undefined: op=1101111 is treated as unsupported (DECODE → FETCH, illegal pulse), and state code 9 is unreachable.

## Test plan
- Reset with rst_n=0 for 2 cycles, then release, mem_ready=1 → state=0; strobes are 0 during reset; IRWrite=1 and PCWrite=1 in the first cycle after release.
- lw (op=0000011), mem_ready=1 → state sequence 0,1,2,3,4,0; ImmSrc=00; RegWrite=1 only in state 4 with ResultSrc=01.
- sw with mem_ready low for 3 cycles in MEMWRITE → MemWrite=1 for 4 consecutive cycles, then state=0; ImmSrc=01; RegWrite stays 0.
- beq with zero=1, then with zero=0 → PCWrite=1 in BEQ, respectively 0; sequence 0,1,10,0; ALUOp=01.
- jal → sequence 0,1,9,7,0 with PCWrite=1 in state 9. Without MULTICYCLE_JAL_EN → sequence 0,1,0 with illegal=1 in DECODE.
- op=0000000 → illegal pulse in DECODE. Reset asserted during MEMREAD stall → state=0 next edge, no RegWrite.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_controller
//  Purpose  : Control FSM sequencing a multicycle RISC-V datapath that shares
//             one ALU and one unified instruction/data memory. Every
//             instruction walks FETCH -> DECODE -> (execute / memory) ->
//             writeback. The FSM drives per-state mux selects and write
//             strobes. Memory states stall on a ready handshake.
//  Ports    : clk        rising-edge clock
//             rst_n      synchronous active-low reset
//             op[6:0]    opcode from the instruction register
//             zero       ALU zero flag (branch resolution)
//             mem_ready  memory completes the current access this cycle
//             mem_req    memory access in progress
//             PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc[1:0],
//             ALUSrcA[1:0], ALUSrcB[1:0], ALUOp[1:0], ImmSrc[1:0], RegWrite
//                        datapath controls
//             illegal    one-cycle pulse on an unsupported opcode in DECODE
//             state[3:0] current state code (debug)
//  Options  : MULTICYCLE_JAL_EN - when defined, jal (1101111) is decoded and
//             the JAL state exists. When undefined, jal is unsupported.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       illegal,
    output logic [3:0] state
);

    // State encoding.
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECUTEI = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    // Opcodes.
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       w_op_supported;

    assign state = r_state;

    // Opcode legality, shared by DECODE branching and the illegal pulse.
    always_comb begin
        w_op_supported = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_BEQ: w_op_supported = 1'b1;
`ifdef MULTICYCLE_JAL_EN
            OP_JAL:                           w_op_supported = 1'b1;
`endif
            default:                          w_op_supported = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:    w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECUTER;
                    OP_I:         w_next_state = S_EXECUTEI;
`ifdef MULTICYCLE_JAL_EN
                    OP_JAL:       w_next_state = S_JAL;
`endif
                    OP_BEQ:       w_next_state = S_BEQ;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: w_next_state = S_ALUWB;
            S_EXECUTEI: w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
`ifdef MULTICYCLE_JAL_EN
            S_JAL:      w_next_state = S_ALUWB;
`endif
            S_BEQ:      w_next_state = S_FETCH;
            // Unused codes (and JAL when the jump is not built) recover here.
            default:    w_next_state = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (Moore, except the ready/zero-qualified strobes)
    // ------------------------------------------------------------------
    always_comb begin
        mem_req   = 1'b0;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        RegWrite  = 1'b0;
        illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                // PC+4 is computed by the ALU and routed straight to the PC.
                // Both enables fire only in the ready cycle so a stalled
                // fetch never double-advances the PC.
                AdrSrc    = 1'b0;
                ALUSrcA   = 2'b00;
                ALUSrcB   = 2'b10;
                ALUOp     = 2'b00;
                ResultSrc = 2'b10;
                mem_req   = 1'b1;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                // Precompute branch/jump target OldPC + imm into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b00;
                illegal = ~w_op_supported;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b00;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                mem_req = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                mem_req  = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b00;
                ALUOp   = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                ResultSrc = 2'b00;
                RegWrite  = 1'b1;
            end
`ifdef MULTICYCLE_JAL_EN
            S_JAL: begin
                // PC <- target held in ALUOut; ALU forms OldPC+4 for rd.
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ALUOp     = 2'b00;
                ResultSrc = 2'b00;
                PCWrite   = 1'b1;
            end
`endif
            S_BEQ: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b00;
                ALUOp     = 2'b01;
                ResultSrc = 2'b00;
                PCWrite   = zero;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase

        // Reset blocks every side effect immediately, not one edge later.
        if (!rst_n) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            mem_req  = 1'b0;
            illegal  = 1'b0;
        end
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_LW, OP_I: ImmSrc = 2'b00;
            OP_SW:       ImmSrc = 2'b01;
            OP_BEQ:      ImmSrc = 2'b10;
            OP_JAL:      ImmSrc = 2'b11;
            default:     ImmSrc = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_controller
//  Purpose  : Directed self-checking bench for multicycle_controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       illegal;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ImmSrc    (ImmSrc),
        .RegWrite  (RegWrite),
        .illegal   (illegal),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample 1 time unit after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; op = 7'b0000011; zero = 1'b0; mem_ready = 1'b1;
        tick; tick;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if ({PCWrite, IRWrite, MemWrite, RegWrite, mem_req, illegal} !== 6'b0) begin
            errors++; $display("FAIL reset_strobes got %b exp 000000", {PCWrite, IRWrite, MemWrite, RegWrite, mem_req, illegal});
        end
        rst_n = 1'b1; #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL release_state got %0d exp 0", state); end
        checks++; if (IRWrite !== 1'b1 || PCWrite !== 1'b1 || mem_req !== 1'b1) begin
            errors++; $display("FAIL release_fetch got IR=%b PC=%b req=%b exp 1 1 1", IRWrite, PCWrite, mem_req);
        end
    endtask

    task automatic test_fetch_stall;
        mem_ready = 1'b0; op = 7'b0000000; #1;
        checks++; if (IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
            errors++; $display("FAIL fetch_stall_strobes got IR=%b PC=%b exp 0 0", IRWrite, PCWrite);
        end
        tick;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL fetch_stall_hold got %0d exp 0", state); end
        mem_ready = 1'b1; #1;
    endtask

    task automatic test_lw;
        logic [3:0] seq [0:5];
        seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        op = 7'b0000011; mem_ready = 1'b1; #1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (state !== seq[i]) begin errors++; $display("FAIL lw_state[%0d] got %0d exp %0d", i, state, seq[i]); end
            checks++; if (RegWrite !== (seq[i] == 4'd4)) begin errors++; $display("FAIL lw_regwrite[%0d] got %b", i, RegWrite); end
            checks++; if (ImmSrc !== 2'b00) begin errors++; $display("FAIL lw_immsrc got %b exp 00", ImmSrc); end
            if (i == 3) begin
                checks++; if (AdrSrc !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL lw_memread got adr=%b req=%b exp 1 1", AdrSrc, mem_req); end
            end
            if (i == 4) begin
                checks++; if (ResultSrc !== 2'b01) begin errors++; $display("FAIL lw_resultsrc got %b exp 01", ResultSrc); end
            end
            if (i < 5) tick;
        end
    endtask

    task automatic test_sw;
        int mw_count;
        mw_count = 0;
        op = 7'b0100011; mem_ready = 1'b1; #1;
        checks++; if (ImmSrc !== 2'b01) begin errors++; $display("FAIL sw_immsrc got %b exp 01", ImmSrc); end
        tick; tick;   // FETCH -> DECODE -> MEMADR
        checks++; if (state !== 4'd2) begin errors++; $display("FAIL sw_memadr got %0d exp 2", state); end
        tick;
        mem_ready = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin mem_ready = 1'b1; #1; end
            checks++; if (state !== 4'd5) begin errors++; $display("FAIL sw_state[%0d] got %0d exp 5", i, state); end
            checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL sw_regwrite got %b exp 0", RegWrite); end
            if (MemWrite === 1'b1) mw_count++;
            tick;
        end
        checks++; if (mw_count != 4) begin errors++; $display("FAIL sw_memwrite_cycles got %0d exp 4", mw_count); end
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL sw_end got %0d exp 0", state); end
    endtask

    task automatic test_beq(input logic z);
        logic [3:0] seq [0:3];
        seq = '{4'd0, 4'd1, 4'd10, 4'd0};
        op = 7'b1100011; zero = z; mem_ready = 1'b1; #1;
        checks++; if (ImmSrc !== 2'b10) begin errors++; $display("FAIL beq_immsrc got %b exp 10", ImmSrc); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (state !== seq[i]) begin errors++; $display("FAIL beq_state[%0d] got %0d exp %0d", i, state, seq[i]); end
            if (i == 2) begin
                checks++; if (PCWrite !== z) begin errors++; $display("FAIL beq_pcwrite got %b exp %b", PCWrite, z); end
                checks++; if (ALUOp !== 2'b01) begin errors++; $display("FAIL beq_aluop got %b exp 01", ALUOp); end
            end
            if (i < 3) tick;
        end
        zero = 1'b0;
    endtask

    task automatic test_rtype;
        logic [3:0] seq [0:4];
        seq = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        op = 7'b0110011; mem_ready = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (state !== seq[i]) begin errors++; $display("FAIL rtype_state[%0d] got %0d exp %0d", i, state, seq[i]); end
            if (i == 2) begin
                checks++; if ({ALUSrcA, ALUSrcB, ALUOp} !== 6'b10_00_10) begin
                    errors++; $display("FAIL rtype_exec got %b exp 100010", {ALUSrcA, ALUSrcB, ALUOp});
                end
            end
            if (i == 3) begin
                checks++; if (RegWrite !== 1'b1 || ResultSrc !== 2'b00) begin
                    errors++; $display("FAIL rtype_wb got rw=%b rs=%b exp 1 00", RegWrite, ResultSrc);
                end
            end
            if (i < 4) tick;
        end
    endtask

    task automatic test_jal;
        op = 7'b1101111; mem_ready = 1'b1; #1;
        checks++; if (ImmSrc !== 2'b11) begin errors++; $display("FAIL jal_immsrc got %b exp 11", ImmSrc); end
        tick;
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL jal_decode got %0d exp 1", state); end
`ifdef MULTICYCLE_JAL_EN
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL jal_illegal got %b exp 0", illegal); end
        tick;
        checks++; if (state !== 4'd9 || PCWrite !== 1'b1) begin errors++; $display("FAIL jal_state got %0d pcw=%b exp 9 1", state, PCWrite); end
        tick;
        checks++; if (state !== 4'd7) begin errors++; $display("FAIL jal_wb got %0d exp 7", state); end
        tick;
`else
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL jal_illegal got %b exp 1", illegal); end
        tick;
`endif
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL jal_end got %0d exp 0", state); end
    endtask

    task automatic test_illegal;
        op = 7'b0000000; mem_ready = 1'b1; #1;
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_fetch got %b exp 0", illegal); end
        tick;
        checks++; if (state !== 4'd1 || illegal !== 1'b1) begin errors++; $display("FAIL ill_decode got st=%0d ill=%b exp 1 1", state, illegal); end
        tick;
        checks++; if (state !== 4'd0 || illegal !== 1'b0) begin errors++; $display("FAIL ill_end got st=%0d ill=%b exp 0 0", state, illegal); end
    endtask

    task automatic test_reset_mid;
        op = 7'b0000011; mem_ready = 1'b1; #1;
        tick; tick; tick;   // DECODE, MEMADR, MEMREAD
        mem_ready = 1'b0; #1;
        tick;
        checks++; if (state !== 4'd3 || RegWrite !== 1'b0) begin errors++; $display("FAIL mid_stall got st=%0d rw=%b exp 3 0", state, RegWrite); end
        rst_n = 1'b0; mem_ready = 1'b1; #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_req got %b exp 0", mem_req); end
        tick;
        checks++; if (state !== 4'd0 || RegWrite !== 1'b0) begin errors++; $display("FAIL mid_reset got st=%0d rw=%b exp 0 0", state, RegWrite); end
        rst_n = 1'b1; #1;
        tick;
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL mid_restart got %0d exp 1", state); end
    endtask

    initial begin
        test_reset;
        test_fetch_stall;
        test_lw;
        test_sw;
        test_beq(1'b1);
        test_beq(1'b0);
        test_rtype;
        test_jal;
        test_illegal;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
